montgomery_mul_ds: RTL
======================

# montgomery_mul_ds

Parametrised digit-serial Montgomery modular multiplier. It computes a·b·R⁻¹ mod m, where R = 2^(n·DIGIT_W) and n = ceil(m_bl/DIGIT_W), and processes one DIGIT_W-bit digit of a per cycle. A mode input turns it into a pure Montgomery-to-normal reduction unit, so it replaces the fixed-width reduction-only `montgomery_ds` in the lattice-crypto datapath. Modulus, inverse and modulus bit length are supplied at run time, so one instance serves several moduli.

## Interface
Parameters:
- DATA_LENGTH, default 64: width of operands, modulus and result.
- DIGIT_W, default 8: digit width, i.e. bits of a consumed per iteration. Must divide DATA_LENGTH.

Ports:
- CLK_pci_sys_clk_p  in  1: single clock, rising edge.
- rst_ni  in  1: reset, asynchronous, active-low.
- start_i  in  1: start request, sampled on the rising edge.
- mode_i  in  1: 0 = multiply (a·b·R⁻¹); 1 = reduce (a·R⁻¹, b_i ignored and treated as 1).
- a_i  in  DATA_LENGTH: operand a, must be < m.
- b_i  in  DATA_LENGTH: operand b, must be < m.
- m_i  in  DATA_LENGTH: modulus, must be odd.
- minv_i  in  DATA_LENGTH: −m⁻¹ mod 2^DIGIT_W. Only the low DIGIT_W bits are used.
- m_bl_i  in  DATA_LENGTH: modulus bit length.
- ready_o  out  1: start_i will be accepted this cycle.
- busy_o  out  1: computation in progress.
- result_o  out  DATA_LENGTH: result, always < m.
- valid_o  out  1: one-cycle pulse, result_o is valid.

## Operation
- States:
  - IDLE: ready_o=1, busy_o=0.
  - ITER: busy_o=1, ready_o=0.
  - CORR: busy_o=1, ready_o=0.
  - DONE: valid_o=1, ready_o=1, busy_o=0.
- IDLE/DONE → ITER when start_i=1. All inputs are latched on that edge; later input changes have no effect. Digit counter is cleared. In mode 1, the latched B is 1.
- Digit count n = ceil(min(m_bl_i, DATA_LENGTH)/DIGIT_W).
  - m_bl_i > DATA_LENGTH is clamped to DATA_LENGTH.
  - m_bl_i = 0 forces n=1.
- ITER, one edge per digit i = 0..n−1:
  - T' = T + a_digit[i]·B
  - q = (T'[DIGIT_W−1:0] · minv) mod 2^DIGIT_W
  - T = (T' + q·M) >> DIGIT_W
  - After digit n−1: go to CORR.
- T is DATA_LENGTH+DIGIT_W+2 bits wide. Invariant T < 2M, no overflow.
- CORR, one edge: result_o ← (T ≥ M) ? T−M : T; go to DONE.
- DONE, one edge: valid_o=1. Next state is ITER if start_i=1, else IDLE.
- result_o holds its value until the next CORR.
- start_i while in ITER or CORR: ignored, no queueing.
- Even m or a,b ≥ m: result undefined; no hang, latency unchanged.

## Timing
- Reset values: state IDLE, ready_o=1, busy_o=0, valid_o=0, result_o=0, T=0, digit counter=0.
- Reset mid-operation aborts immediately. No valid_o pulse follows.
- Start sampled at edge E0:
  - ITER occupies edges E1..En.
  - CORR result registered at En+1.
  - valid_o high in the cycle after En+1 (latency n+1 edges).
- Back-to-back: start_i held high during DONE restarts immediately, giving a throughput of one result per n+2 cycles.
- busy_o and valid_o are never high in the same cycle.

## Structure
- params_pkg: DATA_LENGTH and DIGIT_W defaults, plus test constants MODULUS, MOD_INV (now −m⁻¹ mod 2^DIGIT_W), MODULUS_LENGTH.
- multiplier_pkg: state enum typedef (IDLE, ITER, CORR, DONE).
- One combinational sub-module, `montgomery_digit_step`: (T, digit, B, M, minv) → next T. Kept separate so it can later be pipelined or instantiated per lane.
- Top level holds the FSM, counter, operand registers and the final subtraction. Target size 200–300 lines.

## Test plan
All scenarios use DATA_LENGTH=32, DIGIT_W=8, m=8380417 (0x7FE001), m_bl=23, minv=0xFF. This gives n=3 and R mod m = 16382.
- Reduce: mode=1, a=16382 → result 1, valid_o in the cycle after E4, single pulse.
- Multiply: mode=0, a=16382, b=5 → 5. Then a=b=16382 → 16382.
- Zero and wrap: a=0, b=8380416 → 0. Also a=b=8380416, i.e. (−1)² → checked against a software model of a·b·2⁻²⁴ mod m.
- Handshake: pulse start_i during ITER with different a → ignored, first result unchanged. Hold start_i high through DONE → second op starts, next valid_o 5 cycles later.
- Reset: deassert rst_ni asynchronously during ITER → outputs return to reset values at once, no valid_o. A fresh op then completes correctly.
- Randomised: 1000 random a,b < m in both modes vs a golden model. Include m_bl_i=0 and m_bl_i=40 → clamped n=1 and n=4, result matches the model for that R.

Source files
------------

// File: rtl/montgomery_mul_ds_pkg.sv
// Shared constants and FSM state type for the digit-serial Montgomery multiplier.
// The test constants describe the reference modulus m = 8380417.
package montgomery_mul_ds_pkg;

    localparam int DATA_LENGTH_DEF = 64;
    localparam int DIGIT_W_DEF     = 8;

    localparam logic [31:0] MODULUS        = 32'h007F_E001;
    localparam logic [7:0]  MOD_INV        = 8'hFF;
    localparam logic [31:0] MODULUS_LENGTH = 32'd23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/montgomery_digit_step.sv
// One radix-2^DIGIT_W Montgomery iteration: T <- (T + d*B + q*M) / 2^DIGIT_W.
// Purely combinational so it can later be pipelined or replicated per lane.
module montgomery_digit_step #(
    parameter int DATA_LENGTH = 64,
    parameter int DIGIT_W     = 8,
    parameter int TW          = DATA_LENGTH + DIGIT_W + 2
) (
    input  logic [TW-1:0]          t,
    input  logic [DIGIT_W-1:0]     digit,
    input  logic [DATA_LENGTH-1:0] b,
    input  logic [DATA_LENGTH-1:0] m,
    input  logic [DIGIT_W-1:0]     minv,
    output logic [TW-1:0]          t_next
);

    logic [TW-1:0]      t_prime;
    logic [DIGIT_W-1:0] q;
    logic [TW-1:0]      t_sum;

    // Operands are widened before multiplying so no product bits are lost.
    assign t_prime = t + TW'(digit) * TW'(b);
    assign q       = t_prime[DIGIT_W-1:0] * minv;
    assign t_sum   = t_prime + TW'(q) * TW'(m);
    assign t_next  = t_sum >> DIGIT_W;

endmodule

// File: rtl/montgomery_mul_ds.sv
// Digit-serial Montgomery multiplier / reducer with run-time modulus.
// Computes a*b*R^-1 mod m (mode 0) or a*R^-1 mod m (mode 1), R = 2^(n*DIGIT_W).
module montgomery_mul_ds
    import montgomery_mul_ds_pkg::*;
#(
    parameter int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter int DIGIT_W     = DIGIT_W_DEF
) (
    input  logic                   CLK_pci_sys_clk_p,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   mode_i,
    input  logic [DATA_LENGTH-1:0] a_i,
    input  logic [DATA_LENGTH-1:0] b_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] minv_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic [DATA_LENGTH-1:0] result_o,
    output logic                   valid_o
);

    localparam int TW    = DATA_LENGTH + DIGIT_W + 2;
    localparam int NMAX  = DATA_LENGTH / DIGIT_W;
    localparam int CNT_W = $clog2(NMAX + 1);

    state_t state, state_next;

    logic [DATA_LENGTH-1:0] a_sh;
    logic [DATA_LENGTH-1:0] b_reg;
    logic [DATA_LENGTH-1:0] m_reg;
    logic [DIGIT_W-1:0]     minv_reg;
    logic [CNT_W-1:0]       n_reg;
    logic [CNT_W-1:0]       cnt;
    logic [TW-1:0]          t_reg;
    logic [TW-1:0]          t_next;
    logic [CNT_W-1:0]       n_calc;
    logic                   accept;
    logic                   last_digit;

    assign accept     = start_i && ((state == IDLE) || (state == DONE));
    assign last_digit = (cnt == n_reg - CNT_W'(1));

    // Digit count from the bit length; lengths above DATA_LENGTH saturate at NMAX
    // and a zero length still runs one digit.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        n_calc = CNT_W'(1);
        for (int k = 1; k < NMAX; k++) begin
            if (m_bl_i > DATA_LENGTH'(k * DIGIT_W)) begin
                n_calc = CNT_W'(k + 1);
            end
        end
    end

    montgomery_digit_step #(
        .DATA_LENGTH (DATA_LENGTH),
        .DIGIT_W     (DIGIT_W),
        .TW          (TW)
    ) u_step (
        .t      (t_reg),
        .digit  (a_sh[DIGIT_W-1:0]),
        .b      (b_reg),
        .m      (m_reg),
        .minv   (minv_reg),
        .t_next (t_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = ITER;
            ITER:    if (last_digit) state_next = CORR;
            CORR:    state_next = DONE;
            DONE:    state_next = start_i ? ITER : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (state)
            IDLE:    ready_o = 1'b1;
            ITER:    busy_o  = 1'b1;
            CORR:    busy_o  = 1'b1;
            DONE: begin
                ready_o = 1'b1;
                valid_o = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    // Operands are captured once at start; later input changes are invisible.
    always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh     <= '0;
            b_reg    <= '0;
            m_reg    <= '0;
            minv_reg <= '0;
            n_reg    <= '0;
            cnt      <= '0;
            t_reg    <= '0;
            result_o <= '0;
        end else if (accept) begin
            a_sh     <= a_i;
            b_reg    <= mode_i ? DATA_LENGTH'(1) : b_i;
            m_reg    <= m_i;
            minv_reg <= minv_i[DIGIT_W-1:0];
            n_reg    <= n_calc;
            cnt      <= '0;
            t_reg    <= '0;
        end else if (state == ITER) begin
            t_reg <= t_next;
            a_sh  <= a_sh >> DIGIT_W;
            cnt   <= cnt + CNT_W'(1);
        end else if (state == CORR) begin
            // T < 2M holds throughout, so a single conditional subtract suffices.
            result_o <= (t_reg >= TW'(m_reg)) ? DATA_LENGTH'(t_reg - TW'(m_reg))
                                               : DATA_LENGTH'(t_reg);
        end
    end

endmodule
